// File: rtl/lut_loader_pkg.sv
// rtl/lut_loader_pkg.sv - shared state enum, default widths and depth helper for the LUT loader
package lut_loader_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    VALID = 2'd2
  } lut_state_e;

  localparam int DEF_IN_BITS  = 8;
  localparam int DEF_OUT_BITS = 2;

  function automatic int lut_depth(input int in_bits);
    return 1 << in_bits;
  endfunction

endpackage

// File: rtl/lut_dist_ram.sv
// rtl/lut_dist_ram.sv - one write port, one asynchronous read port table storage
module lut_dist_ram
  import lut_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_IN_BITS,
  parameter int DATA_W = DEF_OUT_BITS
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = lut_depth(ADDR_W);

  // Contents deliberately have no reset; only the loader's valid flag qualifies them.
  (* rom_style = "distributed" *) logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/lut_table_loader.sv
// rtl/lut_table_loader.sv - runtime-loadable truth-table neuron with registered lookup
// Optional trailing XOR checksum beat and cfg_err port: LUT_LOADER_CHECKSUM_EN.
module lut_table_loader
  import lut_loader_pkg::*;
#(
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [OUT_BITS-1:0] cfg_data,
  output logic                cfg_done,
  output logic                tbl_valid,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data,
  output logic                lookup_miss
`ifdef LUT_LOADER_CHECKSUM_EN
  ,
  output logic                cfg_err
`endif
);

  localparam int                 DEPTH     = lut_depth(IN_BITS);
  localparam logic [IN_BITS-1:0] LAST_ADDR = IN_BITS'(DEPTH - 1);

  lut_state_e          state_q;
  logic [IN_BITS-1:0]  addr_q;
  logic                tbl_valid_q;
  logic                cfg_done_q;
  logic                out_valid_q;
  logic                lookup_miss_q;
  logic [OUT_BITS-1:0] out_data_q;
  logic [OUT_BITS-1:0] out_data_d;
  logic [OUT_BITS-1:0] rd_data;
  logic                cfg_hs;
  logic                wr_en;

  assign cfg_ready = (state_q == LOAD) && !cfg_start;
  assign cfg_hs    = cfg_valid && cfg_ready;

`ifdef LUT_LOADER_CHECKSUM_EN
  logic [OUT_BITS-1:0] csum_q;
  logic                csum_phase_q;
  logic                cfg_err_q;

  assign wr_en   = cfg_hs && !csum_phase_q;
  assign cfg_err = cfg_err_q;
`else
  assign wr_en = cfg_hs;
`endif

  lut_dist_ram #(
    .ADDR_W (IN_BITS),
    .DATA_W (OUT_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (addr_q),
    .wdata (cfg_data),
    .raddr (in_data),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      addr_q      <= '0;
      tbl_valid_q <= 1'b0;
      cfg_done_q  <= 1'b0;
`ifdef LUT_LOADER_CHECKSUM_EN
      csum_q       <= '0;
      csum_phase_q <= 1'b0;
      cfg_err_q    <= 1'b0;
`endif
    end else begin
      cfg_done_q <= 1'b0;
`ifdef LUT_LOADER_CHECKSUM_EN
      cfg_err_q <= 1'b0;
      if (cfg_start) begin
        csum_q       <= '0;
        csum_phase_q <= 1'b0;
      end else if (cfg_hs) begin
        if (!csum_phase_q) csum_q <= csum_q ^ cfg_data;
        csum_phase_q <= !csum_phase_q && (addr_q == LAST_ADDR);
      end
`endif
      case (state_q)
        EMPTY: begin
          if (cfg_start) begin
            state_q <= LOAD;
            addr_q  <= '0;
          end
        end
        LOAD: begin
          if (cfg_start) begin
            addr_q <= '0;
          end else if (cfg_hs) begin
`ifdef LUT_LOADER_CHECKSUM_EN
            // The final data beat parks the counter; the next beat is the checksum.
            if (csum_phase_q) begin
              addr_q <= '0;
              if (cfg_data == csum_q) begin
                state_q     <= VALID;
                tbl_valid_q <= 1'b1;
                cfg_done_q  <= 1'b1;
              end else begin
                state_q   <= EMPTY;
                cfg_err_q <= 1'b1;
              end
            end else if (addr_q != LAST_ADDR) begin
              addr_q <= addr_q + 1'b1;
            end
`else
            if (addr_q == LAST_ADDR) begin
              state_q     <= VALID;
              tbl_valid_q <= 1'b1;
              cfg_done_q  <= 1'b1;
              addr_q      <= '0;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
`endif
          end
        end
        VALID: begin
          if (cfg_start) begin
            state_q     <= LOAD;
            tbl_valid_q <= 1'b0;
            addr_q      <= '0;
          end
        end
        default: begin
          state_q     <= EMPTY;
          tbl_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // A lookup against an incomplete table returns zero and flags the miss.
  always_comb begin
    out_data_d = out_data_q;
    if (in_valid) begin
      out_data_d = tbl_valid_q ? rd_data : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      lookup_miss_q <= 1'b0;
    end else begin
      out_valid_q   <= in_valid;
      out_data_q    <= out_data_d;
      lookup_miss_q <= in_valid && !tbl_valid_q;
    end
  end

  assign cfg_done    = cfg_done_q;
  assign tbl_valid   = tbl_valid_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign lookup_miss = lookup_miss_q;

endmodule
